mem_master: RTL and testbench

Initiator for the single-request memory bus: accepts read/write commands from an upstream ready/valid port, issues them to a memory responder as a one-cycle `mem_req` pulse, and waits for `mem_ack`. Errored attempts are retried up to a limit, and a hang is closed out by a timeout. The block returns a response carrying data, status, retry count and latency. It sits between test/control logic and the memory model on the memory-side bus.

---
 rtl/mem_master.sv | 146 ++++++++++++++
 tb/tb_mem_master.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_master.sv
// Single-request memory bus initiator: takes ready/valid commands, issues one mem_req pulse
// per attempt, retries errored acks, times out hung attempts and returns a held response.
module mem_master #(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic        clk_i,
    input  logic        aresetn_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [7:0]  cmd_addr_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    output logic [2:0]  rsp_retries_o,
    output logic [7:0]  rsp_lat_o,
    output logic        mem_req_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [7:0]  mem_addr_o,
    input  logic        mem_ack_i,
    input  logic        mem_err_i,
    input  logic [31:0] mem_data_i
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        write_q, write_d;
    logic [7:0]  addr_q, addr_d;
    logic [2:0]  retry_q, retry_d;
    logic [7:0]  lat_q, lat_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic        tout_q, tout_d;

    logic [7:0]  lat_inc;
    logic [7:0]  wait_inc;

    assign lat_inc  = (lat_q == 8'hff) ? lat_q : lat_q + 8'd1;
    assign wait_inc = wait_q + 8'd1;

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        retry_d = retry_q;
        lat_d   = lat_q;
        wait_d  = wait_q;
        data_d  = data_q;
        err_d   = err_q;
        tout_d  = tout_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    write_d = cmd_write_i;
                    addr_d  = cmd_addr_i;
                    retry_d = 3'd0;
                    lat_d   = 8'd0;
                    data_d  = 32'd0;
                    err_d   = 1'b0;
                    tout_d  = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                lat_d   = lat_inc;
                wait_d  = 8'd0;
                state_d = StWait;
            end
            StWait: begin
                lat_d  = lat_inc;
                wait_d = wait_inc;
                // An ack landing on the final WAIT cycle wins over the timeout.
                if (mem_ack_i) begin
                    if (!mem_err_i) begin
                        data_d  = write_q ? 32'd0 : mem_data_i;
                        state_d = StResp;
                    end else if (retry_q != 3'(MAX_RETRY)) begin
                        retry_d = retry_q + 3'd1;
                        state_d = StReq;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end else if (wait_inc == 8'(TIMEOUT)) begin
                    tout_d  = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            addr_q  <= 8'd0;
            retry_q <= 3'd0;
            lat_q   <= 8'd0;
            wait_q  <= 8'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            retry_q <= retry_d;
            lat_q   <= lat_d;
            wait_q  <= wait_d;
            data_q  <= data_d;
            err_q   <= err_d;
            tout_q  <= tout_d;
        end
    end

    logic active;
    assign active = (state_q == StReq) || (state_q == StWait);

    assign cmd_ready_o   = (state_q == StIdle);
    assign rsp_valid_o   = (state_q == StResp);
    assign rsp_data_o    = data_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = tout_q;
    assign rsp_retries_o = retry_q;
    assign rsp_lat_o     = lat_q;
    assign mem_req_o     = (state_q == StReq);
    assign mem_read_o    = active && !write_q;
    assign mem_write_o   = active && write_q;
    assign mem_addr_o    = addr_q;

endmodule

// File: tb/tb_mem_master.sv
// Randomized bench for mem_master: a scripted responder plays per-attempt delay/err/no-ack
// plans and a plain-arithmetic model predicts the response, latency and pulse count.
module tb_mem_master;

    localparam int TIMEOUT   = 16;
    localparam int MAX_RETRY = 2;
    localparam int NATT      = MAX_RETRY + 1;

    logic        clk;
    logic        aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [2:0]  rsp_retries;
    logic [7:0]  rsp_lat;
    logic        mem_req;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic        mem_err;
    logic [31:0] mem_data;

    mem_master #(
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) u_dut (
        .clk_i         (clk),
        .aresetn_i     (aresetn),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_write_i   (cmd_write),
        .cmd_addr_i    (cmd_addr),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_data_o    (rsp_data),
        .rsp_err_o     (rsp_err),
        .rsp_timeout_o (rsp_timeout),
        .rsp_retries_o (rsp_retries),
        .rsp_lat_o     (rsp_lat),
        .mem_req_o     (mem_req),
        .mem_read_o    (mem_read),
        .mem_write_o   (mem_write),
        .mem_addr_o    (mem_addr),
        .mem_ack_i     (mem_ack),
        .mem_err_i     (mem_err),
        .mem_data_i    (mem_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks;
    int          n_fail;
    int          plan_delay [NATT];
    bit          plan_err   [NATT];
    bit          plan_noack [NATT];
    logic [31:0] plan_data  [NATT];
    int          att_idx;
    int          pulses;
    int          adj;
    int          opbad;
    bit          mon_wr;
    logic [7:0]  mon_addr;
    bit          inject_late;
    bit          prev_req;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_plan(input int i, input int d, input bit e, input bit na,
                            input logic [31:0] dat);
        plan_delay[i] = d;
        plan_err[i]   = e;
        plan_noack[i] = na;
        plan_data[i]  = dat;
    endtask

    // Reference: walk the attempt plan using the bus rules directly.
    task automatic model(input bit wr, output logic [31:0] e_data, output bit e_err,
                         output bit e_tout, output int e_retry, output int e_raw_lat,
                         output int e_att);
        e_data = 0; e_err = 0; e_tout = 0; e_retry = 0; e_raw_lat = 0; e_att = 0;
        for (int i = 0; i < NATT; i++) begin
            e_att++;
            if (plan_noack[i] || plan_delay[i] >= TIMEOUT) begin
                e_raw_lat += 1 + TIMEOUT;
                e_tout = 1;
                break;
            end
            e_raw_lat += 2 + plan_delay[i];
            if (!plan_err[i]) begin
                e_data = wr ? 32'd0 : plan_data[i];
                break;
            end
            if (e_retry < MAX_RETRY) begin
                e_retry++;
            end else begin
                e_err = 1;
                break;
            end
        end
    endtask

    // Responder: ack driven after edge E1+d of each attempt, per the current plan.
    initial begin
        int ai;
        mem_ack  = 1'b0;
        mem_err  = 1'b0;
        mem_data = $urandom;
        forever begin
            @(negedge clk);
            if (inject_late) begin
                inject_late = 1'b0;
                mem_ack  = 1'b1;
                mem_err  = 1'b0;
                mem_data = $urandom;
                @(posedge clk);
                #1 mem_ack = 1'b0;
            end else if (mem_req && aresetn) begin
                ai = att_idx;
                att_idx++;
                if (ai < NATT && !plan_noack[ai]) begin
                    @(posedge clk);
                    repeat (plan_delay[ai]) @(posedge clk);
                    #1;
                    mem_ack  = 1'b1;
                    mem_err  = plan_err[ai];
                    mem_data = plan_data[ai];
                    @(posedge clk);
                    #1;
                    mem_ack  = 1'b0;
                    mem_err  = 1'b0;
                    mem_data = $urandom;
                end
            end
        end
    end

    initial begin
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                pulses++;
                if (prev_req) adj++;
                if (!(mem_read || mem_write)) opbad++;
            end
            if (mem_read || mem_write) begin
                if ((mem_read && mem_write) || (mem_write != mon_wr) || (mem_addr != mon_addr))
                    opbad++;
            end
            prev_req = mem_req;
        end
    end

    task automatic check_reset_outs(input string tag);
        check_val(tag, 32'({cmd_ready, mem_req, mem_read, mem_write, rsp_valid, rsp_err,
                            rsp_timeout, rsp_retries, mem_addr, rsp_lat}), 32'h0200_0000);
        check_val({tag, "_data"}, rsp_data, 32'd0);
    endtask

    task automatic do_txn(input bit wr, input logic [7:0] addr, input int hold, input bit late);
        logic [31:0] e_data;
        bit          e_err;
        bit          e_tout;
        int          e_retry;
        int          e_raw_lat;
        int          e_att;
        int          cyc;
        int          rdy_bad;
        int          unstable;
        bit          got;
        logic [31:0] snap_data;
        logic [31:0] snap_ctl;
        model(wr, e_data, e_err, e_tout, e_retry, e_raw_lat, e_att);
        att_idx = 0; pulses = 0; adj = 0; opbad = 0;
        mon_wr = wr; mon_addr = addr;
        @(negedge clk);
        check_val("idle_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        @(posedge clk);
        // Keeping cmd_valid high while busy must not consume a second command.
        #1 cmd_valid = (hold > 0);
        cyc = 0; got = 0; rdy_bad = 0;
        while (cyc < 400 && !got) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) got = 1;
            else if (cmd_ready) rdy_bad++;
        end
        check_val("rsp_cycle", 32'(cyc), 32'(e_raw_lat + 1));
        check_val("busy_ready", 32'(rdy_bad), 32'd0);
        check_val("rsp_data", rsp_data, e_data);
        check_val("rsp_err", 32'(rsp_err), 32'(e_err));
        check_val("rsp_timeout", 32'(rsp_timeout), 32'(e_tout));
        check_val("rsp_retries", 32'(rsp_retries), 32'(e_retry));
        check_val("rsp_lat", 32'(rsp_lat), 32'((e_raw_lat > 255) ? 255 : e_raw_lat));
        check_val("req_pulses", 32'(pulses), 32'(e_att));
        check_val("adjacent_req", 32'(adj), 32'd0);
        check_val("op_addr", 32'(opbad), 32'd0);
        snap_data = rsp_data;
        snap_ctl  = 32'({rsp_err, rsp_timeout, rsp_retries, rsp_lat});
        unstable  = 0;
        if (late) inject_late = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!rsp_valid || cmd_ready || rsp_data !== snap_data ||
                32'({rsp_err, rsp_timeout, rsp_retries, rsp_lat}) !== snap_ctl)
                unstable++;
        end
        if (hold > 0) check_val("stall_stable", 32'(unstable), 32'd0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check_val("post_rsp", 32'({rsp_valid, cmd_ready, mem_req}), 32'b010);
        if (late) begin
            unstable = 0;
            inject_late = 1'b1;
            repeat (4) begin
                @(negedge clk);
                if (!cmd_ready || rsp_valid || mem_req) unstable++;
            end
            check_val("idle_late_ack", 32'(unstable), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_fail = 0;
        att_idx = 0; pulses = 0; adj = 0; opbad = 0;
        inject_late = 1'b0;
        mon_wr = 1'b0; mon_addr = 8'd0;
        for (int i = 0; i < NATT; i++) set_plan(i, 0, 0, 0, 32'd0);
        aresetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'd0;
        rsp_ready = 1'b0;
        #12;
        check_reset_outs("reset");
        @(negedge clk);
        aresetn = 1'b1;

        set_plan(0, 0, 0, 0, 32'h55);
        do_txn(1'b0, 8'h10, 5, 1'b0);
        set_plan(0, 7, 0, 0, 32'h1234_5678);
        do_txn(1'b1, 8'h80, 0, 1'b0);
        set_plan(0, 0, 1, 0, 32'hAAAA_0001);
        set_plan(1, 0, 1, 0, 32'hAAAA_0002);
        set_plan(2, 0, 0, 0, 32'hCAFE_F00D);
        do_txn(1'b0, 8'h20, 0, 1'b0);
        set_plan(0, 1, 1, 0, 32'h1);
        set_plan(1, 3, 1, 0, 32'h2);
        set_plan(2, 0, 1, 0, 32'h3);
        do_txn(1'b0, 8'h33, 2, 1'b0);
        set_plan(0, 0, 0, 1, 32'h0);
        do_txn(1'b0, 8'h44, 5, 1'b1);
        set_plan(0, 15, 0, 0, 32'h0BAD_BEEF);
        do_txn(1'b0, 8'h5A, 0, 1'b0);
        set_plan(0, 16, 0, 0, 32'hFFFF_0000);
        do_txn(1'b0, 8'h5B, 0, 1'b0);

        // Reset while an attempt is waiting: everything drops at once, no response follows.
        set_plan(0, 0, 0, 1, 32'h0);
        att_idx = 0;
        mon_wr = 1'b1; mon_addr = 8'h66;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h66;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check_val("in_wait", 32'({mem_write, mem_req, cmd_ready}), 32'b100);
        #2 aresetn = 1'b0;
        #1;
        check_reset_outs("mid_reset");
        @(negedge clk);
        aresetn = 1'b1;
        set_plan(0, 2, 0, 0, 32'h7777_1111);
        do_txn(1'b0, 8'h67, 0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < NATT; i++) begin
                set_plan(i, $urandom_range(0, 16), ($urandom_range(0, 2) == 0),
                         ($urandom_range(0, 9) == 0), $urandom);
            end
            do_txn(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
